// File: rtl/fifo_uart_tx.sv
// FIFO-drain UART transmitter: pops one word per frame and sends start, data LSB-first, [parity], stop.
// Optional even parity bit is built when UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int width        = 8,
    parameter int clks_per_bit = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [width-1:0] fifo_dout_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int BW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int CW = $clog2(width + 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(clks_per_bit - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state;
    logic [BW-1:0]    baud_cnt;
    logic [CW-1:0]    bit_cnt;
    logic [width-1:0] shift;
    logic             baud_done;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    assign baud_done = (baud_cnt == BAUD_MAX);

    // tx_o is registered from the current state, so the line trails the state by one
    // cycle; the popped word lands on fifo_dout_i during START's first cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            tx_o         <= 1'b1;
            busy_o       <= 1'b0;
            fifo_rd_en_o <= 1'b0;
            bit_cnt      <= '0;
            baud_cnt     <= '0;
            shift        <= '0;
`ifdef UART_TX_PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            fifo_rd_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    tx_o     <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty_i) begin
                        fifo_rd_en_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    tx_o     <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= START;
                end
                START: begin
                    tx_o <= 1'b0;
                    if (baud_cnt == '0) begin
                        shift  <= fifo_dout_i;
`ifdef UART_TX_PARITY_EN
                        parity <= ^fifo_dout_i;
`endif
                    end
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx_o <= shift[0];
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_o <= parity;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx_o <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        busy_o   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-backed fifo model, expected bytes scoreboarded and
// compared against words decoded from tx_o.
module tb_fifo_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = (2 + W + PB) * CPB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] dout = '0;
    logic         fifo_empty = 1'b1;
    logic         rd_en;
    logic         tx;
    logic         busy;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int n_chk = 0, n_err = 0;
    int cyc = 0, last_rd_cyc = 0, rd_cnt = 0, tx_low_cnt = 0, pop_empty = 0;

    fifo_uart_tx #(.width(W), .clks_per_bit(CPB)) dut (
        .clk_i(clk), .reset_i(rst_n), .fifo_dout_i(dout), .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(rd_en), .tx_o(tx), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // fifo model: word appears on dout the cycle after the pop strobe
    always @(posedge clk) begin
        if (rd_en) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (fifo_q.size() == 0) pop_empty++;
            else dout <= fifo_q.pop_front();
            fifo_empty <= (fifo_q.size() == 0);
        end
        if (!tx) tx_low_cnt++;
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_start(output int gap, output bit seen);
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                seen = 1'b1;
                break;
            end
            gap++;
        end
        chk("frame_start", 32'(seen), 1);
    endtask

    // Decode one frame mid-bit; exp_gap < 0 skips the idle-gap check.
    task automatic recv(input int exp_gap);
        int gap, n0;
        bit seen;
        logic [W-1:0] d, e;
        logic par;
        wait_start(gap, seen);
        if (!seen) return;
        n0 = cyc;
        if (exp_gap >= 0) chk("idle_gap", gap, exp_gap);
        chk("pop_to_start", n0 - last_rd_cyc, 2);
        chk("busy_in_frame", 32'(busy), 1);
        repeat (2) @(negedge clk);
        chk("start_bit", 32'(tx), 0);
        for (int i = 0; i < W; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = tx;
        end
        par = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = tx;
`endif
        repeat (CPB) @(negedge clk);
        chk("stop_bit", 32'(tx), 1);
        repeat (1) @(negedge clk);
        chk("stop_tail", 32'(tx), 1);
        chk("frame_len", cyc - last_rd_cyc + 1, FL + 2);
        chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("data", 32'(d), 32'(e));
`ifdef UART_TX_PARITY_EN
        chk("parity", 32'(par), 32'(^e));
`else
        chk("no_parity_bit", 32'(par), 0);
`endif
    endtask

    initial begin
        int gap, snap_rd, snap_low;
        bit seen;
        logic [W-1:0] w;

        rst_n = 1'b0;
        @(negedge clk);
        push(8'hf0);
        repeat (5) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 1);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rd_en", 32'(rd_en), 0);
        end
        chk("rst_no_pop", rd_cnt, 0);
        rst_n = 1'b1;

        recv(-1);
        @(negedge clk);
        chk("busy_after_frame", 32'(busy), 0);
        chk("single_pop", rd_cnt, 1);

        snap_rd  = rd_cnt;
        snap_low = tx_low_cnt;
        repeat (100) @(negedge clk);
        chk("empty_no_pop", rd_cnt, snap_rd);
        chk("empty_tx_high", tx_low_cnt, snap_low);

        push(8'h55);
        push(8'hA3);
        recv(-1);
        recv(2);

        // abort during data bit 3 of 'hA5 (bit 3 is 0, so the line must visibly rise)
        w = 8'hA5;
        push(w);
        wait_start(gap, seen);
        repeat (4 * CPB + 1) @(negedge clk);
        chk("pre_abort_bit3", 32'(tx), 32'(w[3]));
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_tx", 32'(tx), 1);
        chk("abort_busy", 32'(busy), 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        push(8'h96);
        recv(-1);

`ifdef UART_TX_PARITY_EN
        push(8'h07);
        recv(-1);
        push(8'h03);
        recv(-1);
`endif

        repeat (5) @(negedge clk);
        chk("pop_while_empty", pop_empty, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
